// File: rtl/ctl_xfer_sequencer.sv
// ctl_xfer_sequencer
//   USB EP0 control-transfer sequencer. Latches each SETUP packet, routes
//   the request to the standard or user handler, chunks the handler's byte
//   stream into MAX_PACKET-sized IN packets (with ZLP insertion and wLength
//   truncation), holds the request through the status stage, and answers
//   STALL for unclaimed or unsupported requests.
//
// Ports
//   clock, reset                  clock, async active-high reset
//   setup_valid_i, setup_data_i   SETUP strobe and 8 SETUP bytes
//   ctl_xfer_*_o                  latched SETUP fields
//   std_req_o/std_gnt_i           standard handler request/grant
//   usr_req_o/usr_gnt_i           user (class/vendor) handler request/grant
//   std_t*, usr_t*                handler byte streams (AXI4-Stream)
//   in_token_i                    host IN token for EP0
//   in_t*                         IN packet payload stream
//   in_zlp_o                      send zero-length IN packet (strobe)
//   status_ack_i                  status stage handshake done (strobe)
//   stall_o                       answer STALL on EP0
//   xfer_done_o                   transfer completed (strobe)
module ctl_xfer_sequencer #(
  parameter int MAX_PACKET  = 64,
  parameter int GNT_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        setup_valid_i,
  input  logic [63:0] setup_data_i,
  output logic [7:0]  ctl_xfer_type_o,
  output logic [7:0]  ctl_xfer_request_o,
  output logic [15:0] ctl_xfer_value_o,
  output logic [15:0] ctl_xfer_index_o,
  output logic [15:0] ctl_xfer_length_o,
  output logic        std_req_o,
  output logic        usr_req_o,
  input  logic        std_gnt_i,
  input  logic        usr_gnt_i,
  input  logic        std_tvalid_i,
  input  logic        std_tlast_i,
  input  logic [7:0]  std_tdata_i,
  output logic        std_tready_o,
  input  logic        usr_tvalid_i,
  input  logic        usr_tlast_i,
  input  logic [7:0]  usr_tdata_i,
  output logic        usr_tready_o,
  input  logic        in_token_i,
  output logic        in_tvalid_o,
  output logic        in_tlast_o,
  output logic [7:0]  in_tdata_o,
  input  logic        in_tready_i,
  output logic        in_zlp_o,
  input  logic        status_ack_i,
  output logic        stall_o,
  output logic        xfer_done_o
);

  localparam int PW = $clog2(MAX_PACKET + 1);
  localparam int TW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_GNT, S_DATA_IN, S_ZLP, S_STATUS, S_STALL
  } state_t;

  state_t         state;
  logic           pend;       // SETUP latched during abort, start it from IDLE
  logic           pkt_open;   // IN packet in progress
  logic [15:0]    remaining;
  logic [PW-1:0]  pkt_cnt;
  logic [TW-1:0]  gnt_cnt;

  logic           sel_usr, sel_gnt, dir_in;
  logic           src_tvalid, src_tlast;
  logic [7:0]     src_tdata;
  logic           pkt_full, last_byte, beat;
  logic [7:0]     idle_type;

  always_comb begin
    sel_usr    = ctl_xfer_type_o[6:5] != 2'b00;
    dir_in     = ctl_xfer_type_o[7];
    sel_gnt    = sel_usr ? usr_gnt_i    : std_gnt_i;
    src_tvalid = sel_usr ? usr_tvalid_i : std_tvalid_i;
    src_tlast  = sel_usr ? usr_tlast_i  : std_tlast_i;
    src_tdata  = sel_usr ? usr_tdata_i  : std_tdata_i;
    pkt_full   = pkt_cnt == PW'(MAX_PACKET - 1);
    last_byte  = remaining == 16'd1;
    // zero-latency pass-through, only while a packet is open
    in_tvalid_o  = pkt_open & src_tvalid;
    in_tdata_o   = pkt_open ? src_tdata : 8'h00;
    in_tlast_o   = pkt_open & (pkt_full | last_byte | src_tlast);
    std_tready_o = pkt_open & ~sel_usr & in_tready_i;
    usr_tready_o = pkt_open &  sel_usr & in_tready_i;
    beat         = pkt_open & src_tvalid & in_tready_i;
    // handler selection for the request raised on leaving IDLE
    idle_type    = setup_valid_i ? setup_data_i[7:0] : ctl_xfer_type_o;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      pend               <= 1'b0;
      pkt_open           <= 1'b0;
      remaining          <= '0;
      pkt_cnt            <= '0;
      gnt_cnt            <= '0;
      ctl_xfer_type_o    <= '0;
      ctl_xfer_request_o <= '0;
      ctl_xfer_value_o   <= '0;
      ctl_xfer_index_o   <= '0;
      ctl_xfer_length_o  <= '0;
      std_req_o          <= 1'b0;
      usr_req_o          <= 1'b0;
      stall_o            <= 1'b0;
      xfer_done_o        <= 1'b0;
      in_zlp_o           <= 1'b0;
    end else begin
      xfer_done_o <= 1'b0;
      in_zlp_o    <= 1'b0;

      if (setup_valid_i) begin
        ctl_xfer_type_o    <= setup_data_i[7:0];
        ctl_xfer_request_o <= setup_data_i[15:8];
        ctl_xfer_value_o   <= setup_data_i[31:16];
        ctl_xfer_index_o   <= setup_data_i[47:32];
        ctl_xfer_length_o  <= setup_data_i[63:48];
        remaining          <= setup_data_i[63:48];
        pkt_cnt            <= '0;
        pkt_open           <= 1'b0;
        gnt_cnt            <= '0;
      end

      // a SETUP outside IDLE wins over everything else this cycle
      if (setup_valid_i && state != S_IDLE) begin
        state     <= S_IDLE;
        pend      <= 1'b1;
        std_req_o <= 1'b0;
        usr_req_o <= 1'b0;
        stall_o   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (setup_valid_i || pend) begin
              state     <= S_WAIT_GNT;
              pend      <= 1'b0;
              std_req_o <= idle_type[6:5] == 2'b00;
              usr_req_o <= idle_type[6:5] != 2'b00;
            end
          end
          S_WAIT_GNT: begin
            if (sel_gnt) begin
              if (ctl_xfer_length_o == 16'd0) begin
                state <= S_STATUS;
              end else if (dir_in) begin
                state <= S_DATA_IN;
              end else begin
                // OUT data stages are not supported
                state     <= S_STALL;
                stall_o   <= 1'b1;
                std_req_o <= 1'b0;
                usr_req_o <= 1'b0;
              end
            end else if (gnt_cnt == TW'(GNT_TIMEOUT - 1)) begin
              state     <= S_STALL;
              stall_o   <= 1'b1;
              std_req_o <= 1'b0;
              usr_req_o <= 1'b0;
            end else begin
              gnt_cnt <= gnt_cnt + TW'(1);
            end
          end
          S_DATA_IN: begin
            if (!pkt_open && in_token_i) pkt_open <= 1'b1;
            if (beat) begin
              remaining <= remaining - 16'd1;
              if (in_tlast_o) begin
                pkt_cnt  <= '0;
                pkt_open <= 1'b0;
              end else begin
                pkt_cnt <= pkt_cnt + PW'(1);
              end
              if (last_byte || src_tlast) begin
                // short of wLength on a full packet: host needs a ZLP to end
                if (src_tlast && remaining > 16'd1 && pkt_full) state <= S_ZLP;
                else                                            state <= S_STATUS;
              end
            end
          end
          S_ZLP: begin
            if (in_token_i) begin
              in_zlp_o <= 1'b1;
              state    <= S_STATUS;
            end
          end
          S_STATUS: begin
            // handlers commit SET_ADDRESS etc. on the falling edge of req
            if (status_ack_i) begin
              std_req_o   <= 1'b0;
              usr_req_o   <= 1'b0;
              xfer_done_o <= 1'b1;
              state       <= S_IDLE;
            end
          end
          S_STALL: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctl_xfer_sequencer.sv
// Directed testbench for ctl_xfer_sequencer: descriptor reads with short
// source, wLength truncation, ZLP insertion, no-data request, grant timeout,
// SETUP abort mid data stage and async reset mid packet.
module tb_ctl_xfer_sequencer;
  localparam int MP = 64;
  localparam int GT = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        setup_valid = 1'b0;
  logic [63:0] setup_data = '0;
  logic        std_gnt = 1'b0, usr_gnt = 1'b0;
  logic        std_tvalid = 1'b0, std_tlast = 1'b0;
  logic [7:0]  std_tdata = '0;
  logic        usr_tvalid = 1'b0, usr_tlast = 1'b0;
  logic [7:0]  usr_tdata = '0;
  logic        in_token = 1'b0, in_tready = 1'b0, status_ack = 1'b0;

  logic [7:0]  ctl_xfer_type_o, ctl_xfer_request_o;
  logic [15:0] ctl_xfer_value_o, ctl_xfer_index_o, ctl_xfer_length_o;
  logic        std_req_o, usr_req_o, std_tready_o, usr_tready_o;
  logic        in_tvalid_o, in_tlast_o, in_zlp_o, stall_o, xfer_done_o;
  logic [7:0]  in_tdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  ctl_xfer_sequencer #(.MAX_PACKET(MP), .GNT_TIMEOUT(GT)) dut (
    .clock(clock), .reset(reset),
    .setup_valid_i(setup_valid), .setup_data_i(setup_data),
    .ctl_xfer_type_o(ctl_xfer_type_o), .ctl_xfer_request_o(ctl_xfer_request_o),
    .ctl_xfer_value_o(ctl_xfer_value_o), .ctl_xfer_index_o(ctl_xfer_index_o),
    .ctl_xfer_length_o(ctl_xfer_length_o),
    .std_req_o(std_req_o), .usr_req_o(usr_req_o),
    .std_gnt_i(std_gnt), .usr_gnt_i(usr_gnt),
    .std_tvalid_i(std_tvalid), .std_tlast_i(std_tlast), .std_tdata_i(std_tdata),
    .std_tready_o(std_tready_o),
    .usr_tvalid_i(usr_tvalid), .usr_tlast_i(usr_tlast), .usr_tdata_i(usr_tdata),
    .usr_tready_o(usr_tready_o),
    .in_token_i(in_token),
    .in_tvalid_o(in_tvalid_o), .in_tlast_o(in_tlast_o), .in_tdata_o(in_tdata_o),
    .in_tready_i(in_tready),
    .in_zlp_o(in_zlp_o), .status_ack_i(status_ack),
    .stall_o(stall_o), .xfer_done_o(xfer_done_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic setup(input logic [7:0] t, input logic [7:0] r,
                       input logic [15:0] v, input logic [15:0] i, input logic [15:0] l);
    setup_valid = 1'b1;
    setup_data  = {l, i, v, r, t};
    tick;
    setup_valid = 1'b0;
  endtask

  task automatic grant_std;
    std_gnt = 1'b1; tick; std_gnt = 1'b0;
  endtask

  task automatic token;
    in_token = 1'b1; tick; in_token = 1'b0;
  endtask

  task automatic ack;
    status_ack = 1'b1; tick; status_ack = 1'b0;
  endtask

  // Streams nbeats bytes A0,A1,... from the standard handler; source marks
  // tlast on byte nsrc. Optionally inserts one in_tready stall at beat 3.
  task automatic stream(input string tag, input int nbeats, input int nsrc,
                        input int wlen, input bit hiccup);
    int  i = 0;
    bit  stalled = 1'b0;
    logic exp_last;
    while (i < nbeats) begin
      std_tvalid = 1'b1;
      std_tdata  = 8'(8'hA0 + i);
      std_tlast  = (i == nsrc - 1);
      in_tready  = !(hiccup && i == 3 && !stalled);
      #1;
      if (in_tready) begin
        exp_last = (i % MP == MP - 1) || (i == wlen - 1) || (i == nsrc - 1);
        chk(tag, 32'({in_tvalid_o, in_tlast_o, std_tready_o, in_tdata_o}),
                 32'({1'b1, exp_last, 1'b1, 8'(8'hA0 + i)}));
      end else begin
        stalled = 1'b1;
        chk({tag, "_hold"}, 32'(std_tready_o), 32'(0));
      end
      tick;
      if (in_tready) i++;
    end
    std_tvalid = 1'b0;
    std_tlast  = 1'b0;
    in_tready  = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clock);
    #1;
    chk("reset_out", 32'({std_req_o, usr_req_o, stall_o, xfer_done_o, in_zlp_o,
                          in_tvalid_o, in_tlast_o, std_tready_o, usr_tready_o, in_tdata_o}), 32'(0));
    chk("reset_f0", 32'({ctl_xfer_type_o, ctl_xfer_request_o, ctl_xfer_length_o}), 32'(0));
    chk("reset_f1", 32'({ctl_xfer_value_o, ctl_xfer_index_o}), 32'(0));
    reset = 1'b0;
    tick;

    // GET_DESCRIPTOR(device), wLength 64, source 18 bytes
    setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd64);
    chk("t1_req", 32'({std_req_o, usr_req_o}), 32'(2'b10));
    chk("t1_f0", 32'({ctl_xfer_type_o, ctl_xfer_request_o, ctl_xfer_length_o}), 32'h8006_0040);
    chk("t1_f1", 32'({ctl_xfer_value_o, ctl_xfer_index_o}), 32'h0100_0000);
    grant_std;
    std_tvalid = 1'b1; in_tready = 1'b1;
    #1;
    chk("t1_closed", 32'({in_tvalid_o, std_tready_o}), 32'(0));
    std_tvalid = 1'b0; in_tready = 1'b0;
    token;
    stream("t1_beat", 18, 18, 64, 1'b1);
    token;
    chk("t1_nozlp", 32'({in_zlp_o, std_req_o}), 32'(2'b01));
    ack;
    chk("t1_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));
    tick;
    chk("t1_done_pulse", 32'(xfer_done_o), 32'(0));

    // GET_DESCRIPTOR(config), wLength 9, source 18 bytes
    setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd9);
    grant_std;
    token;
    stream("t2_beat", 9, 18, 9, 1'b0);
    std_tvalid = 1'b1; std_tdata = 8'hA9; in_tready = 1'b1;
    #1;
    chk("t2_trunc", 32'({in_tvalid_o, in_tlast_o, std_tready_o}), 32'(0));
    tick;
    std_tvalid = 1'b0; in_tready = 1'b0;
    ack;
    chk("t2_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));

    // 64-byte source ending on a full packet, wLength 255 -> ZLP
    setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd255);
    grant_std;
    token;
    stream("t3_beat", 64, 64, 255, 1'b0);
    chk("t3_zlp_wait", 32'(in_zlp_o), 32'(0));
    token;
    chk("t3_zlp", 32'(in_zlp_o), 32'(1));
    tick;
    chk("t3_zlp_pulse", 32'(in_zlp_o), 32'(0));
    ack;
    chk("t3_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));

    // same with wLength 64 -> no ZLP
    setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd64);
    grant_std;
    token;
    stream("t3b_beat", 64, 64, 64, 1'b0);
    token;
    chk("t3b_nozlp", 32'(in_zlp_o), 32'(0));
    ack;
    chk("t3b_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));

    // SET_ADDRESS, no data stage
    setup(8'h00, 8'h05, 16'h0012, 16'h0000, 16'd0);
    grant_std;
    chk("t4_req", 32'({std_req_o, stall_o}), 32'(2'b10));
    repeat (3) tick;
    chk("t4_hold", 32'(std_req_o), 32'(1));
    ack;
    chk("t4_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));

    // vendor request, grant never comes -> STALL after GT cycles
    setup(8'h40, 8'h01, 16'h0000, 16'h0000, 16'd0);
    chk("t5_req", 32'({std_req_o, usr_req_o}), 32'(2'b01));
    repeat (GT - 1) tick;
    chk("t5_wait", 32'({stall_o, usr_req_o}), 32'(2'b01));
    tick;
    chk("t5_stall", 32'({stall_o, usr_req_o}), 32'(2'b10));
    setup(8'h80, 8'h00, 16'h0000, 16'h0000, 16'd2);
    chk("t5_clear", 32'({stall_o, std_req_o, usr_req_o}), 32'(0));
    tick;
    chk("t5_rereq", 32'({std_req_o, usr_req_o}), 32'(2'b10));

    // new SETUP mid data stage, coinciding with a data beat
    setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd40);
    tick;
    chk("t6_req", 32'(std_req_o), 32'(1));
    grant_std;
    token;
    stream("t6_beat", 10, 40, 40, 1'b0);
    std_tvalid = 1'b1; std_tdata = 8'hAA; in_tready = 1'b1;
    setup(8'h80, 8'h06, 16'h0200, 16'h0000, 16'd9);
    std_tvalid = 1'b0; in_tready = 1'b0;
    chk("t6_abort", 32'({std_req_o, std_tready_o, xfer_done_o}), 32'(0));
    chk("t6_len", 32'(ctl_xfer_length_o), 32'd9);
    tick;
    chk("t6_rereq", 32'(std_req_o), 32'(1));
    grant_std;
    token;
    stream("t6b_beat", 9, 18, 9, 1'b0);
    ack;
    chk("t6b_done", 32'({xfer_done_o, std_req_o}), 32'(2'b10));

    // async reset in the middle of an open packet
    setup(8'h80, 8'h06, 16'h0100, 16'h0000, 16'd40);
    grant_std;
    token;
    stream("t7_beat", 3, 40, 40, 1'b0);
    std_tvalid = 1'b1; std_tdata = 8'hA3; in_tready = 1'b1;
    #1;
    chk("t7_pre_reset", 32'({in_tvalid_o, std_tready_o, std_req_o}), 32'(3'b111));
    #1 reset = 1'b1;
    #1;
    chk("t7_reset_out", 32'({std_req_o, usr_req_o, stall_o, xfer_done_o, in_zlp_o,
                             in_tvalid_o, in_tlast_o, std_tready_o, usr_tready_o, in_tdata_o}), 32'(0));
    chk("t7_reset_f0", 32'({ctl_xfer_type_o, ctl_xfer_request_o, ctl_xfer_length_o}), 32'(0));
    #1 reset = 1'b0;
    std_tvalid = 1'b0; in_tready = 1'b0;
    tick;
    chk("t7_idle", 32'({std_req_o, in_tvalid_o}), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctl_xfer_sequencer.md
# ctl_xfer_sequencer

Control-transfer sequencer for USB endpoint 0. It sits between the token/packet layer and the EP0 request handlers: the standard-request descriptor/config pipe and a user (class/vendor) request handler. It latches each SETUP packet and routes the request to exactly one handler. It then runs the data stage, chunking the handler's byte stream into max-packet-sized IN packets with ZLP insertion and wLength truncation, and holds the request through the status stage. Unclaimed requests are answered with STALL.

## Interface
- `MAX_PACKET`, 64: EP0 max packet size in bytes (8/16/32/64).
- `GNT_TIMEOUT`, 8: cycles to wait for a handler grant before stalling (≥2).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `setup_valid_i`  in  1  one-cycle strobe: a valid SETUP packet is on `setup_data_i`.
- `setup_data_i`  in  64  SETUP bytes, byte 0 in [7:0] (bmRequestType, bRequest, wValue, wIndex, wLength; little-endian).
- `ctl_xfer_type_o` / `ctl_xfer_request_o`  out  8 / 8  latched bmRequestType / bRequest.
- `ctl_xfer_value_o` / `ctl_xfer_index_o` / `ctl_xfer_length_o`  out  16 each  latched wValue / wIndex / wLength.
- `std_req_o`, `usr_req_o`  out  1  request to the standard handler (type[6:5]==00) or the user handler (otherwise).
- `std_gnt_i`, `usr_gnt_i`  in  1  handler accepts the request.
- `std_tvalid_i`, `std_tlast_i`, `std_tdata_i[7:0]`; `std_tready_o`: standard handler byte stream (AXI4-Stream).
- `usr_tvalid_i`, `usr_tlast_i`, `usr_tdata_i[7:0]`; `usr_tready_o`: user handler byte stream.
- `in_token_i`  in  1  strobe: host IN token for EP0; the packet layer wants a data packet.
- `in_tvalid_o`, `in_tlast_o`, `in_tdata_o[7:0]`; `in_tready_i`: IN packet payload; `in_tlast_o` marks the last byte of the packet.
- `in_zlp_o`  out  1  one-cycle strobe: send a zero-length IN packet.
- `status_ack_i`  in  1  strobe: status stage handshake completed.
- `stall_o`  out  1  EP0 must answer STALL.
- `xfer_done_o`  out  1  one-cycle strobe at successful completion.

## Operation
- States: IDLE, WAIT_GNT, DATA_IN, ZLP, STATUS, STALL.
- **IDLE:**
  - On `setup_valid_i`: latch all fields. Next cycle enter WAIT_GNT and assert the selected `*_req_o`.
  - Clear `remaining` to wLength and `pkt_cnt` to 0.
- **WAIT_GNT:**
  - Count cycles. On gnt from the selected handler:
    - Direction=IN (type[7]=1) and wLength≠0 → DATA_IN.
    - wLength==0 → STATUS.
    - Direction=OUT and wLength≠0 → STALL (OUT data stages unsupported).
  - No gnt after GNT_TIMEOUT cycles → STALL. Drop req.
- **DATA_IN:**
  - A packet opens on `in_token_i` and stays open until its tlast beat.
  - While open, the stream is a combinational pass-through:
    - `in_tvalid_o` = src_tvalid.
    - `src_tready` = `in_tready_i`.
    - `in_tdata_o` = src_tdata.
    - Nonselected handler tready is held 0.
  - `in_tlast_o` is asserted when any of: `pkt_cnt`==MAX_PACKET-1, `remaining`==1, or src_tlast.
  - Each accepted beat: `remaining`-1, `pkt_cnt`+1. `pkt_cnt` clears after the tlast beat.
  - Transfer ends on a beat with `remaining`==1 or src_tlast:
    - If it ended by src_tlast, `remaining`>1, and the final packet held exactly MAX_PACKET bytes → ZLP.
    - Otherwise → STATUS.
  - Source bytes beyond wLength are never consumed; the handler discards them when req drops.
- **ZLP:** on `in_token_i`, pulse `in_zlp_o` for one cycle → STATUS.
- **STATUS:** req stays high (handlers commit SET_ADDRESS/SET_CONFIGURATION on req fall). On `status_ack_i`: drop req, pulse `xfer_done_o`, → IDLE.
- **STALL:** `stall_o`=1 and req low until the next `setup_valid_i`.
- **Abort:** `setup_valid_i` in any non-IDLE state drops req, clears `stall_o`, and latches the new SETUP. The new request goes through IDLE, so req is low for at least one cycle before reasserting.

## Timing
- Reset: state=IDLE. All outputs are 0, including latched fields, `remaining`, and `pkt_cnt`.
- Latency:
  - SETUP strobe at cycle 0 → `*_req_o` high at cycle 1.
  - gnt seen at cycle n → new state at n+1.
  - Timeout: STALL entered on cycle GNT_TIMEOUT after WAIT_GNT entry.
- Stream:
  - Zero added latency on the data path.
  - One byte per cycle when both sides are ready.
  - Stall cycles (tvalid or tready low) hold the counters.
- `in_token_i` while a packet is already open is ignored. `in_token_i` in IDLE, STATUS, or STALL is ignored.
- `status_ack_i` outside STATUS is ignored.
- Simultaneous `setup_valid_i` with `status_ack_i`, or with a data beat: the SETUP wins. No `xfer_done_o`, and counters reload.
- Widths: `remaining` 16-bit, never underflows. `pkt_cnt` is $clog2(MAX_PACKET+1) bits.

## Test plan
- GET_DESCRIPTOR(device), wLength=64, std handler supplies 18 bytes with tlast on byte 18 → one IN packet of 18 bytes, `in_tlast_o` on byte 18, no ZLP, STATUS; ack → `xfer_done_o`, `std_req_o` low next cycle.
- GET_DESCRIPTOR(config), wLength=9, source 18 bytes → 9 bytes sent, `in_tlast_o` on byte 9, source tready 0 afterwards, STATUS.
- MAX_PACKET=64, source 64 bytes + tlast, wLength=255 → 64-byte packet, next `in_token_i` → `in_zlp_o` one cycle; the same with wLength=64 → no ZLP.
- SET_ADDRESS (type 00, wLength=0) → no data stage; `std_req_o` stays high until `status_ack_i`, drops one cycle later.
- Vendor request (type 40h), `usr_gnt_i` never asserted → `stall_o`=1 at WAIT_GNT entry+GNT_TIMEOUT, `usr_req_o` low; next SETUP clears `stall_o`.
- New SETUP mid-DATA_IN after 10 of 40 bytes → req low one cycle, counters reloaded, new request proceeds; async `reset` mid-packet → all outputs 0 immediately.
